coin_dispenser_n: RTL and testbench

Parametrised change dispenser for the vending machine datapath: accepts a change amount in cents through a start/busy/done handshake and dispenses it as a greedy sequence of single-cycle coin pulses. It tracks a per-channel coin inventory, skips empty channels, and reports any amount it could not pay. It sits between the transaction controller, which computes the change, and the coin-hopper drivers. It supersedes the fixed quarter/dime/nickel dispenser.

---
 rtl/coin_dispenser_n.sv | 187 ++++++++++++++++++
 tb/tb_coin_dispenser_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/coin_dispenser_n.sv
// Greedy change dispenser with per-channel coin inventory.
// Optional 100-cent channel enabled by defining COIN_DOLLAR_EN.
module coin_dispenser_n #(
  parameter int CHANGE_W = 10,
  parameter int INV_W    = 8,
  parameter int INV_INIT = 20,
  parameter int GAP      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CHANGE_W-1:0] change,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CHANGE_W-1:0] shortfall,
  output logic                outquarter,
  output logic                outdime,
  output logic                outnickel,
`ifdef COIN_DOLLAR_EN
  output logic                outdollar,
  input  logic [INV_W-1:0]    load_dl,
  output logic [INV_W-1:0]    inv_dl,
`endif
  input  logic                load,
  input  logic [INV_W-1:0]    load_q,
  input  logic [INV_W-1:0]    load_d,
  input  logic [INV_W-1:0]    load_n,
  output logic [INV_W-1:0]    inv_q,
  output logic [INV_W-1:0]    inv_d,
  output logic [INV_W-1:0]    inv_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PULSE, S_WAIT, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_NICKEL, C_DIME, C_QTR, C_DOLLAR
  } coin_e;

  localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);
  localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_e              state_q, state_d;
  coin_e               sel_q, sel_d;
  coin_e               pick;
  logic [CHANGE_W-1:0] rem_q, rem_d;
  logic [CHANGE_W-1:0] sf_q, sf_d;
  logic [CHANGE_W-1:0] val;
  logic [3:0]          gap_q, gap_d;
  logic [INV_W-1:0]    iq_q, iq_d;
  logic [INV_W-1:0]    id_q, id_d;
  logic [INV_W-1:0]    in_q, in_d;
  logic [INV_W-1:0]    idl_q, idl_d;

  // Largest affordable coin whose channel is not empty
  always_comb begin
    pick = C_NONE;
    priority case (1'b1)
`ifdef COIN_DOLLAR_EN
      (rem_q >= CHANGE_W'(100)) && (idl_q != '0):
        pick = C_DOLLAR;
`endif
      (rem_q >= CHANGE_W'(25)) && (iq_q != '0):
        pick = C_QTR;
      (rem_q >= CHANGE_W'(10)) && (id_q != '0):
        pick = C_DIME;
      (rem_q >= CHANGE_W'(5)) && (in_q != '0):
        pick = C_NICKEL;
      default: pick = C_NONE;
    endcase
  end

  // Value of the registered coin selection
  always_comb begin
    val = '0;
    unique case (sel_q)
      C_DOLLAR: val = CHANGE_W'(100);
      C_QTR:    val = CHANGE_W'(25);
      C_DIME:   val = CHANGE_W'(10);
      C_NICKEL: val = CHANGE_W'(5);
      default:  val = '0;
    endcase
  end

  // Next-state, remaining amount and inventory bookkeeping
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    sf_d    = sf_q;
    gap_d   = gap_q;
    iq_d    = iq_q;
    id_d    = id_q;
    in_d    = in_q;
    idl_d   = idl_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          iq_d = load_q;
          id_d = load_d;
          in_d = load_n;
`ifdef COIN_DOLLAR_EN
          idl_d = load_dl;
`endif
        end else if (start) begin
          rem_d   = change;
          sf_d    = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (pick == C_NONE) begin
          sf_d    = rem_q;
          state_d = S_DONE;
        end else begin
          sel_d   = pick;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        rem_d = rem_q - val;
        unique case (sel_q)
          C_DOLLAR: idl_d = idl_q - 1'b1;
          C_QTR:    iq_d  = iq_q - 1'b1;
          C_DIME:   id_d  = id_q - 1'b1;
          C_NICKEL: in_d  = in_q - 1'b1;
          default:  ;
        endcase
        if (GAP > 0) begin
          gap_d   = GAP_LD;
          state_d = S_WAIT;
        end else begin
          state_d = S_SELECT;
        end
      end
      S_WAIT: begin
        if (gap_q == '0) state_d = S_SELECT;
        else gap_d = gap_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sel_q   <= C_NONE;
      rem_q   <= '0;
      sf_q    <= '0;
      gap_q   <= '0;
      iq_q    <= INV_RST;
      id_q    <= INV_RST;
      in_q    <= INV_RST;
      idl_q   <= INV_RST;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      sf_q    <= sf_d;
      gap_q   <= gap_d;
      iq_q    <= iq_d;
      id_q    <= id_d;
      in_q    <= in_d;
      idl_q   <= idl_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = done && (rem_q != '0);
  assign shortfall  = sf_q;
  assign outquarter = (state_q == S_PULSE) && (sel_q == C_QTR);
  assign outdime    = (state_q == S_PULSE) && (sel_q == C_DIME);
  assign outnickel  = (state_q == S_PULSE) && (sel_q == C_NICKEL);
  assign inv_q      = iq_q;
  assign inv_d      = id_q;
  assign inv_n      = in_q;
`ifdef COIN_DOLLAR_EN
  assign outdollar  = (state_q == S_PULSE) && (sel_q == C_DOLLAR);
  assign inv_dl     = idl_q;
`endif

endmodule

// File: tb/tb_coin_dispenser_n.sv
// Directed bench for coin_dispenser_n (GAP = 1).
// Vector table plus hand sequences for abort and ignored requests.
module tb_coin_dispenser_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] change;
  logic       busy, done, err;
  logic [9:0] shortfall;
  logic       outquarter, outdime, outnickel;
  logic       load;
  logic [7:0] load_q, load_d, load_n;
  logic [7:0] inv_q, inv_d, inv_n;
`ifdef COIN_DOLLAR_EN
  logic       outdollar;
  logic [7:0] load_dl;
  logic [7:0] inv_dl;
`endif

  coin_dispenser_n dut (
    .clk(clk), .rst(rst), .start(start), .change(change),
    .busy(busy), .done(done), .err(err), .shortfall(shortfall),
    .outquarter(outquarter), .outdime(outdime), .outnickel(outnickel),
`ifdef COIN_DOLLAR_EN
    .outdollar(outdollar), .load_dl(load_dl), .inv_dl(inv_dl),
`endif
    .load(load), .load_q(load_q), .load_d(load_d), .load_n(load_n),
    .inv_q(inv_q), .inv_d(inv_d), .inv_n(inv_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ldv;
    int lq, ld, ln;
    int ch;
    int eq, ed, en;
    int eerr, esf;
    int iq, id, inn;
  } vec_t;

  vec_t vt[8];
  int errors = 0;
  int checks = 0;

  int r_nq, r_nd, r_nn, r_ndl, r_done, r_err, r_sf, r_bad;
  int pulses;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int q, input int d, input int n, input int dl);
    load = 1'b1;
    load_q = 8'(q);
    load_d = 8'(d);
    load_n = 8'(n);
`ifdef COIN_DOLLAR_EN
    load_dl = 8'(dl);
`endif
    step();
    load = 1'b0;
  endtask

  // Runs one transaction; inj > 0 pokes start/load at that cycle.
  task automatic do_txn(input int ch, input int inj);
    int c;
    int p;
    int lastv;
    int v;
    int nout;
    r_nq = 0; r_nd = 0; r_nn = 0; r_ndl = 0;
    r_done = -1; r_err = -1; r_sf = -1; r_bad = 0;
    p = 0;
    lastv = 1000;
    start = 1'b1;
    change = 10'(ch);
    step();
    start = 1'b0;
    change = 10'h3ff;
    c = 1;
    while (c <= 400) begin
      if (!busy) r_bad++;
      v = 0;
      nout = 0;
      if (outquarter) begin v = 25; nout++; r_nq++; end
      if (outdime) begin v = 10; nout++; r_nd++; end
      if (outnickel) begin v = 5; nout++; r_nn++; end
`ifdef COIN_DOLLAR_EN
      if (outdollar) begin v = 100; nout++; r_ndl++; end
`endif
      if (nout > 1) r_bad++;
      if (nout > 0) begin
        if (c != 2 + 3 * p) r_bad++;
        if (v > lastv) r_bad++;
        lastv = v;
        p++;
      end
      if (done) begin
        r_done = c;
        r_err = int'(err);
        r_sf = int'(shortfall);
        break;
      end
      if (inj > 0 && c == inj) begin
        start = 1'b1;
        change = 10'd25;
        do_load(0, 0, 0, 0);
        start = 1'b0;
        c++;
        continue;
      end
      step();
      c++;
    end
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 0, 40, 1, 1, 1, 0, 0, 19, 19, 19};
    vt[1] = '{0, 0, 0, 0, 75, 3, 0, 0, 0, 0, 16, 19, 19};
    vt[2] = '{1, 0, 2, 20, 60, 0, 2, 8, 0, 0, 0, 0, 12};
    vt[3] = '{1, 0, 0, 1, 17, 0, 0, 1, 1, 12, 0, 0, 0};
    vt[4] = '{1, 20, 20, 20, 0, 0, 0, 0, 0, 0, 20, 20, 20};
    vt[5] = '{1, 5, 5, 5, 3, 0, 0, 0, 1, 3, 5, 5, 5};
    vt[6] = '{1, 1, 1, 1, 95, 1, 1, 1, 1, 55, 0, 0, 0};
    vt[7] = '{1, 20, 20, 20, 1023, 20, 20, 20, 1, 223, 0, 0, 0};

    rst = 1'b0; start = 1'b0; change = '0; load = 1'b0;
    load_q = '0; load_d = '0; load_n = '0;
`ifdef COIN_DOLLAR_EN
    load_dl = '0;
`endif
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_short", int'(shortfall), 0);
    chk("rst_outs", int'({outquarter, outdime, outnickel}), 0);
    chk("rst_inv_q", int'(inv_q), 20);
    chk("rst_inv_d", int'(inv_d), 20);
    chk("rst_inv_n", int'(inv_n), 20);
    rst = 1'b1;
    step();

    foreach (vt[i]) begin
      if (vt[i].ldv) do_load(vt[i].lq, vt[i].ld, vt[i].ln, 0);
      do_txn(vt[i].ch, 0);
      chk($sformatf("v%0d_nq", i), r_nq, vt[i].eq);
      chk($sformatf("v%0d_nd", i), r_nd, vt[i].ed);
      chk($sformatf("v%0d_nn", i), r_nn, vt[i].en);
      chk($sformatf("v%0d_done_cyc", i), r_done,
          2 + 3 * (vt[i].eq + vt[i].ed + vt[i].en));
      chk($sformatf("v%0d_err", i), r_err, vt[i].eerr);
      chk($sformatf("v%0d_short", i), r_sf, vt[i].esf);
      chk($sformatf("v%0d_protocol", i), r_bad, 0);
      step();
      chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
      chk($sformatf("v%0d_short_held", i), int'(shortfall), vt[i].esf);
      chk($sformatf("v%0d_inv_q", i), int'(inv_q), vt[i].iq);
      chk($sformatf("v%0d_inv_d", i), int'(inv_d), vt[i].id);
      chk($sformatf("v%0d_inv_n", i), int'(inv_n), vt[i].inn);
    end

    do_load(20, 20, 20, 0);
    do_txn(40, 3);
    chk("ign_nq", r_nq, 1);
    chk("ign_nd", r_nd, 1);
    chk("ign_nn", r_nn, 1);
    chk("ign_done_cyc", r_done, 11);
    step();
    chk("ign_busy_after", int'(busy), 0);
    chk("ign_inv_q", int'(inv_q), 19);
    chk("ign_inv_d", int'(inv_d), 19);
    chk("ign_inv_n", int'(inv_n), 19);

    load = 1'b1;
    load_q = 8'd7; load_d = 8'd8; load_n = 8'd9;
    start = 1'b1;
    change = 10'd40;
    step();
    load = 1'b0;
    start = 1'b0;
    chk("ldst_busy", int'(busy), 0);
    chk("ldst_inv_q", int'(inv_q), 7);
    chk("ldst_inv_d", int'(inv_d), 8);
    chk("ldst_inv_n", int'(inv_n), 9);
    step();
    chk("ldst_busy2", int'(busy), 0);

    do_load(20, 20, 20, 0);
    start = 1'b1;
    change = 10'd40;
    step();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) step();
    chk("abort_in_wait", int'(busy && !outdime && !done), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (outquarter || outdime || outnickel || done || busy) pulses++;
      step();
    end
    chk("abort_quiet", pulses, 0);
    chk("abort_inv_q", int'(inv_q), 20);
    chk("abort_inv_d", int'(inv_d), 20);
    chk("abort_inv_n", int'(inv_n), 20);
    chk("abort_short", int'(shortfall), 0);

`ifdef COIN_DOLLAR_EN
    do_load(20, 20, 20, 20);
    do_txn(140, 0);
    chk("dl_ndl", r_ndl, 1);
    chk("dl_nq", r_nq, 1);
    chk("dl_nd", r_nd, 1);
    chk("dl_nn", r_nn, 1);
    chk("dl_done_cyc", r_done, 14);
    chk("dl_err", r_err, 0);
    chk("dl_protocol", r_bad, 0);
    step();
    chk("dl_inv_dl", int'(inv_dl), 19);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
